// File: rtl/vga_ds_pkg.sv
// Shared types and default widths for the VGA/debug register read scheduler.
package vga_ds_pkg;

  localparam int ADDR_W_DEF     = 5;
  localparam int DATA_W_DEF     = 32;
  localparam int STARVE_LIM_DEF = 4;

  typedef enum logic [1:0] {IDLE, READ, DONE} state_t;
  typedef enum logic       {GNT_VGA, GNT_DBG} owner_t;

endpackage

// File: rtl/vga_sched_arb.sv
// Picks the owner of the next register read from pending flags and the VGA streak.
// Purely combinational; VGA is favoured until the streak limit is reached.
module vga_sched_arb
  import vga_ds_pkg::*;
#(
  parameter int STARVE_LIM = STARVE_LIM_DEF,
  parameter int STREAK_W   = $clog2(STARVE_LIM + 1)
) (
  input  logic                vga_pend,
  input  logic                dbg_pend,
  input  logic [STREAK_W-1:0] streak,
  output logic                gnt,
  output logic                owner
);

  always_comb begin
    gnt   = vga_pend | dbg_pend;
    owner = GNT_VGA;
    if (dbg_pend && (!vga_pend || streak == STREAK_W'(STARVE_LIM)))
      owner = GNT_DBG;
  end

endmodule

// File: rtl/vga_reg_sched.sv
// Shares one register read port between VGA and debug; request-to-valid latency 2 cycles, one read per 3 cycles.
// No backpressure: VGA requests coalesce (latest address wins), debug requests while busy are dropped; VGA_REG_SCHED_STATS_EN adds counters.
module vga_reg_sched
  import vga_ds_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_valid,
  output logic [DATA_W-1:0] vga_data,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_busy,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_data,
  output logic [ADDR_W-1:0] regAddr,
  input  logic [DATA_W-1:0] regData
`ifdef VGA_REG_SCHED_STATS_EN
  ,
  output logic [15:0]       vga_cnt,
  output logic [15:0]       dbg_cnt
`endif
);

  localparam int STREAK_W = $clog2(STARVE_LIM + 1);

  state_t              state, state_nxt;
  owner_t              owner_q;
  logic                vga_pend, dbg_pend, vga_rearm;
  logic [ADDR_W-1:0]   vga_addr_q, dbg_addr_q;
  logic [STREAK_W-1:0] streak;
  logic                dbg_accept, vga_pend_eff, dbg_pend_eff;
  logic                arb_gnt, arb_owner, grant;
  logic                done_vga, done_dbg;

  // Pulses arriving in IDLE are visible to the arbiter in the same cycle.
  assign dbg_accept   = dbg_req & ~dbg_pend;
  assign vga_pend_eff = vga_pend | vga_req;
  assign dbg_pend_eff = dbg_pend | dbg_accept;
  assign grant        = (state == IDLE) & arb_gnt;
  assign done_vga     = (state == DONE) & (owner_q == GNT_VGA);
  assign done_dbg     = (state == DONE) & (owner_q == GNT_DBG);

  vga_sched_arb #(
    .STARVE_LIM (STARVE_LIM),
    .STREAK_W   (STREAK_W)
  ) u_arb (
    .vga_pend (vga_pend_eff),
    .dbg_pend (dbg_pend_eff),
    .streak   (streak),
    .gnt      (arb_gnt),
    .owner    (arb_owner)
  );

  always_ff @(posedge clk) begin
    if (resetn) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = READ;
      READ:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    vga_valid = ~resetn & done_vga;
    dbg_ack   = ~resetn & done_dbg;
    dbg_busy  = ~resetn & dbg_pend;
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      owner_q    <= GNT_VGA;
      vga_pend   <= 1'b0;
      dbg_pend   <= 1'b0;
      vga_rearm  <= 1'b0;
      vga_addr_q <= '0;
      dbg_addr_q <= '0;
      streak     <= '0;
      regAddr    <= '0;
      vga_data   <= '0;
      dbg_data   <= '0;
    end else begin
      if (vga_req)    vga_addr_q <= vga_addr;
      if (dbg_accept) dbg_addr_q <= dbg_addr;

      // A VGA request during its own service must survive the DONE clear.
      if (vga_req)                    vga_pend <= 1'b1;
      else if (done_vga && !vga_rearm) vga_pend <= 1'b0;

      if (state != IDLE && owner_q == GNT_VGA) vga_rearm <= vga_rearm | vga_req;
      else                                     vga_rearm <= 1'b0;

      if (dbg_accept)    dbg_pend <= 1'b1;
      else if (done_dbg) dbg_pend <= 1'b0;

      if (!dbg_pend_eff)                     streak <= '0;
      else if (grant && arb_owner == GNT_DBG) streak <= '0;
      else if (grant)                        streak <= streak + STREAK_W'(1);

      if (grant) begin
        owner_q <= owner_t'(arb_owner);
        regAddr <= (arb_owner == GNT_DBG) ? (dbg_accept ? dbg_addr : dbg_addr_q)
                                          : (vga_req    ? vga_addr : vga_addr_q);
      end

      if (state == READ) begin
        if (owner_q == GNT_VGA) vga_data <= regData;
        else                    dbg_data <= regData;
      end
    end
  end

`ifdef VGA_REG_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (resetn) begin
      vga_cnt <= '0;
      dbg_cnt <= '0;
    end else begin
      if (done_vga && vga_cnt != 16'hFFFF) vga_cnt <= vga_cnt + 16'd1;
      if (done_dbg && dbg_cnt != 16'hFFFF) dbg_cnt <= dbg_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_reg_sched.sv
// Directed bench for vga_reg_sched: reset, single reads, arbitration, starvation, coalescing, mid-read reset.
module tb_vga_reg_sched;

  logic        clk = 1'b0;
  logic        resetn;
  logic        vga_req, dbg_req;
  logic [4:0]  vga_addr, dbg_addr;
  logic        vga_valid, dbg_busy, dbg_ack;
  logic [31:0] vga_data, dbg_data, regData;
  logic [4:0]  regAddr;
`ifdef VGA_REG_SCHED_STATS_EN
  logic [15:0] vga_cnt, dbg_cnt;
`endif

  int errs = 0;
  int checks = 0;

  logic       clr = 1'b0, rec = 1'b0;
  int         nv, nd;
  logic [15:0] seq;

  always #5 clk = ~clk;

  function automatic logic [31:0] rf(input logic [4:0] a);
    rf = (a == 5'd3) ? 32'hDEADBEEF : (32'h1000_0000 + {27'd0, a} * 32'h0101);
  endfunction

  assign regData = rf(regAddr);

  vga_reg_sched dut (
    .clk       (clk),
    .resetn    (resetn),
    .vga_req   (vga_req),
    .vga_addr  (vga_addr),
    .vga_valid (vga_valid),
    .vga_data  (vga_data),
    .dbg_req   (dbg_req),
    .dbg_addr  (dbg_addr),
    .dbg_busy  (dbg_busy),
    .dbg_ack   (dbg_ack),
    .dbg_data  (dbg_data),
    .regAddr   (regAddr),
    .regData   (regData)
`ifdef VGA_REG_SCHED_STATS_EN
    ,
    .vga_cnt   (vga_cnt),
    .dbg_cnt   (dbg_cnt)
`endif
  );

  // Event recorder: 0 = vga_valid, 1 = dbg_ack, oldest at the high end.
  always @(negedge clk) begin
    if (clr) begin
      nv = 0; nd = 0; seq = '0;
    end else if (rec) begin
      if (vga_valid) begin nv++; seq = {seq[14:0], 1'b0}; end
      if (dbg_ack)   begin nd++; seq = {seq[14:0], 1'b1}; end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic start_rec();
    rec = 1'b0; clr = 1'b1; cyc(); clr = 1'b0; rec = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b1; vga_req = 0; dbg_req = 0; vga_addr = 0; dbg_addr = 0;
    cyc(); cyc();
    checks++; if (vga_valid !== 1'b0) begin errs++; $display("FAIL reset_vga_valid got %0b want 0", vga_valid); end
    checks++; if (dbg_ack !== 1'b0)   begin errs++; $display("FAIL reset_dbg_ack got %0b want 0", dbg_ack); end
    checks++; if (dbg_busy !== 1'b0)  begin errs++; $display("FAIL reset_dbg_busy got %0b want 0", dbg_busy); end
    checks++; if (regAddr !== 5'd0)   begin errs++; $display("FAIL reset_regAddr got %0d want 0", regAddr); end
    checks++; if (vga_data !== 32'd0) begin errs++; $display("FAIL reset_vga_data got %h want 0", vga_data); end
    checks++; if (dbg_data !== 32'd0) begin errs++; $display("FAIL reset_dbg_data got %h want 0", dbg_data); end
    resetn = 1'b0;
    cyc();
  endtask

  task automatic test_vga_only();
    vga_req = 1; vga_addr = 5'd3;
    cyc(); vga_req = 0;
    checks++; if (regAddr !== 5'd3)  begin errs++; $display("FAIL vga_only_regAddr got %0d want 3", regAddr); end
    checks++; if (vga_valid !== 1'b0) begin errs++; $display("FAIL vga_only_early_valid got %0b want 0", vga_valid); end
    cyc();
    checks++; if (vga_valid !== 1'b1) begin errs++; $display("FAIL vga_only_valid got %0b want 1", vga_valid); end
    checks++; if (vga_data !== 32'hDEADBEEF) begin errs++; $display("FAIL vga_only_data got %h want deadbeef", vga_data); end
    checks++; if (dbg_ack !== 1'b0)   begin errs++; $display("FAIL vga_only_dbg_ack got %0b want 0", dbg_ack); end
    cyc();
    checks++; if (vga_valid !== 1'b0) begin errs++; $display("FAIL vga_only_pulse_width got %0b want 0", vga_valid); end
    checks++; if (vga_data !== 32'hDEADBEEF) begin errs++; $display("FAIL vga_only_hold got %h want deadbeef", vga_data); end
  endtask

  task automatic test_simultaneous();
    vga_req = 1; vga_addr = 5'd1; dbg_req = 1; dbg_addr = 5'd2;
    cyc(); vga_req = 0; dbg_req = 0;
    checks++; if (regAddr !== 5'd1)  begin errs++; $display("FAIL simul_regAddr_vga got %0d want 1", regAddr); end
    checks++; if (dbg_busy !== 1'b1) begin errs++; $display("FAIL simul_busy got %0b want 1", dbg_busy); end
    cyc();
    checks++; if (vga_valid !== 1'b1) begin errs++; $display("FAIL simul_vga_valid got %0b want 1", vga_valid); end
    checks++; if (vga_data !== rf(5'd1)) begin errs++; $display("FAIL simul_vga_data got %h want %h", vga_data, rf(5'd1)); end
    cyc(); cyc();
    checks++; if (regAddr !== 5'd2)  begin errs++; $display("FAIL simul_regAddr_dbg got %0d want 2", regAddr); end
    cyc();
    checks++; if (dbg_ack !== 1'b1)  begin errs++; $display("FAIL simul_dbg_ack got %0b want 1", dbg_ack); end
    checks++; if (dbg_data !== rf(5'd2)) begin errs++; $display("FAIL simul_dbg_data got %h want %h", dbg_data, rf(5'd2)); end
    checks++; if (vga_valid !== 1'b0) begin errs++; $display("FAIL simul_vga_quiet got %0b want 0", vga_valid); end
    cyc();
    checks++; if (dbg_busy !== 1'b0) begin errs++; $display("FAIL simul_busy_clear got %0b want 0", dbg_busy); end
  endtask

  task automatic test_rearm();
    vga_req = 1; vga_addr = 5'd1;
    cyc(); vga_addr = 5'd6;
    cyc(); vga_req = 0;
    checks++; if (vga_data !== rf(5'd1)) begin errs++; $display("FAIL rearm_first_data got %h want %h", vga_data, rf(5'd1)); end
    cyc(); cyc();
    checks++; if (regAddr !== 5'd6) begin errs++; $display("FAIL rearm_regAddr got %0d want 6", regAddr); end
    cyc();
    checks++; if (vga_valid !== 1'b1 || vga_data !== rf(5'd6)) begin errs++; $display("FAIL rearm_second got valid=%0b data=%h want 1/%h", vga_valid, vga_data, rf(5'd6)); end
    cyc();
  endtask

  task automatic wait_valid(input string tag);
    bit seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      cyc();
      if (vga_valid) seen = 1;
    end
    checks++; if (!seen) begin errs++; $display("FAIL %s_timeout got no vga_valid want one within 20 cycles", tag); end
  endtask

  task automatic test_starvation();
    start_rec();
    vga_req = 1; vga_addr = 5'd4; dbg_req = 1; dbg_addr = 5'd8;
    cyc(); vga_req = 0; dbg_req = 0;
    for (int i = 0; i < 5; i++) begin
      wait_valid("starve");
      cyc(); vga_req = 1; vga_addr = 5'(10 + i);
      cyc(); vga_req = 0;
    end
    wait_valid("starve_last");
    cyc(); cyc(); cyc(); cyc();
    rec = 0;
    checks++; if (nv != 6 || nd != 1) begin errs++; $display("FAIL starve_counts got nv=%0d nd=%0d want 6/1", nv, nd); end
    checks++; if (seq[6:0] !== 7'b0000100) begin errs++; $display("FAIL starve_order got %b want 0000100", seq[6:0]); end
    checks++; if (dbg_data !== rf(5'd8)) begin errs++; $display("FAIL starve_dbg_data got %h want %h", dbg_data, rf(5'd8)); end
  endtask

  task automatic test_overwrite();
    start_rec();
    dbg_req = 1; dbg_addr = 5'd4;
    cyc(); dbg_addr = 5'd9; vga_req = 1; vga_addr = 5'd5;
    checks++; if (dbg_busy !== 1'b1) begin errs++; $display("FAIL ovw_busy got %0b want 1", dbg_busy); end
    cyc(); dbg_req = 0; vga_addr = 5'd7;
    checks++; if (dbg_ack !== 1'b1 || dbg_data !== rf(5'd4)) begin errs++; $display("FAIL ovw_dbg got ack=%0b data=%h want 1/%h", dbg_ack, dbg_data, rf(5'd4)); end
    cyc(); vga_req = 0;
    cyc();
    checks++; if (regAddr !== 5'd7) begin errs++; $display("FAIL ovw_regAddr got %0d want 7", regAddr); end
    for (int k = 0; k < 8; k++) cyc();
    rec = 0;
    checks++; if (nv != 1 || nd != 1) begin errs++; $display("FAIL ovw_counts got nv=%0d nd=%0d want 1/1", nv, nd); end
    checks++; if (vga_data !== rf(5'd7)) begin errs++; $display("FAIL ovw_vga_data got %h want %h", vga_data, rf(5'd7)); end
    checks++; if (dbg_data !== rf(5'd4)) begin errs++; $display("FAIL ovw_dbg_data got %h want %h", dbg_data, rf(5'd4)); end
  endtask

  task automatic test_reset_mid();
    start_rec();
    vga_req = 1; vga_addr = 5'd3;
    cyc(); vga_req = 0; resetn = 1; dbg_req = 1; dbg_addr = 5'd2;
    checks++; if (vga_valid !== 1'b0) begin errs++; $display("FAIL rmid_valid_in_reset got %0b want 0", vga_valid); end
    cyc(); resetn = 0; dbg_req = 0;
    checks++; if ({vga_valid, dbg_ack, dbg_busy} !== 3'b000) begin errs++; $display("FAIL rmid_flags got %b want 000", {vga_valid, dbg_ack, dbg_busy}); end
    checks++; if (regAddr !== 5'd0 || vga_data !== 32'd0 || dbg_data !== 32'd0) begin errs++; $display("FAIL rmid_regs got a=%0d v=%h d=%h want 0", regAddr, vga_data, dbg_data); end
    cyc(); cyc(); cyc();
    checks++; if (nv != 0 || nd != 0) begin errs++; $display("FAIL rmid_no_pulse got nv=%0d nd=%0d want 0/0", nv, nd); end
    rec = 0;
    vga_req = 1; vga_addr = 5'd2;
    cyc(); vga_req = 0;
    cyc();
    checks++; if (vga_valid !== 1'b1 || vga_data !== rf(5'd2)) begin errs++; $display("FAIL rmid_recover got valid=%0b data=%h want 1/%h", vga_valid, vga_data, rf(5'd2)); end
    cyc();
  endtask

`ifdef VGA_REG_SCHED_STATS_EN
  task automatic one_read(input bit is_dbg, input logic [4:0] a);
    if (is_dbg) begin dbg_req = 1; dbg_addr = a; end
    else begin vga_req = 1; vga_addr = a; end
    cyc(); vga_req = 0; dbg_req = 0;
    cyc(); cyc(); cyc();
  endtask

  task automatic test_stats();
    resetn = 1; cyc(); resetn = 0; cyc();
    for (int i = 0; i < 3; i++) one_read(1'b0, 5'(i));
    for (int i = 0; i < 2; i++) one_read(1'b1, 5'(i + 4));
    checks++; if (vga_cnt !== 16'd3) begin errs++; $display("FAIL stats_vga_cnt got %0d want 3", vga_cnt); end
    checks++; if (dbg_cnt !== 16'd2) begin errs++; $display("FAIL stats_dbg_cnt got %0d want 2", dbg_cnt); end
    force dut.vga_cnt = 16'hFFFF;
    cyc();
    release dut.vga_cnt;
    one_read(1'b0, 5'd1);
    checks++; if (vga_cnt !== 16'hFFFF) begin errs++; $display("FAIL stats_saturate got %h want ffff", vga_cnt); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_vga_only();
    test_simultaneous();
    test_rearm();
    test_starvation();
    test_overwrite();
    test_reset_mid();
`ifdef VGA_REG_SCHED_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/vga_reg_sched.md
VGA_REG_SCHED -- requirements
Module: vga_reg_sched

Interface
REQ-001 Parameter ADDR_W, default 5, width of the register address.
REQ-002 Parameter DATA_W, default 32, width of the register data.
REQ-003 Parameter STARVE_LIM, default 4, maximum consecutive VGA grants while a debug request is pending.
REQ-004 clk  input  1  clock; all logic is clocked on its rising edge.
REQ-005 resetn  input  1  reset; synchronous, active-high (1 = reset asserted).
REQ-006 vga_req  input  1  one-cycle pulse from the VGA side requesting a register read.
REQ-007 vga_addr  input  ADDR_W  register index for the VGA request, sampled while vga_req=1.
REQ-008 vga_valid  output  1  one-cycle pulse; vga_data has been updated.
REQ-009 vga_data  output  DATA_W  last register value fetched for the VGA side; holds between fetches.
REQ-010 dbg_req  input  1  one-cycle pulse from the debug requester requesting a register read.
REQ-011 dbg_addr  input  ADDR_W  register index for the debug request, sampled while dbg_req=1.
REQ-012 dbg_busy  output  1  high while a debug request is pending or in service.
REQ-013 dbg_ack  output  1  one-cycle pulse; dbg_data is valid.
REQ-014 dbg_data  output  DATA_W  last register value fetched for the debug side; holds between fetches.
REQ-015 regAddr  output  ADDR_W  address to the shared CPU register read port.
REQ-016 regData  input  DATA_W  combinational read data from the CPU register port, for the current regAddr.

Function
REQ-017 The FSM SHALL have the states IDLE, READ and DONE; IDLE->READ on grant, READ->DONE always, DONE->IDLE always.
REQ-018 A vga_req pulse SHALL set vga_pend and latch vga_addr; a pulse while VGA is already pending or in service SHALL overwrite the latched address (latest wins) and SHALL NOT create a second fetch.
REQ-019 A dbg_req pulse while dbg_busy=0 SHALL set dbg_pend and latch dbg_addr; a pulse while dbg_busy=1 SHALL be ignored.
REQ-020 Arbitration SHALL occur only in IDLE: VGA wins when both requests are pending, unless streak==STARVE_LIM, in which case debug wins.
REQ-021 streak SHALL increment on a VGA grant while dbg_pend=1, and SHALL clear on a debug grant or whenever dbg_pend=0.
REQ-022 A request pulse arriving in IDLE SHALL be grantable in that same cycle, so the FSM enters READ on the next edge.
REQ-023 In READ, regAddr SHALL equal the granted address; regData SHALL be captured into the winner's data register at the end of READ.
REQ-024 In DONE, exactly one of vga_valid or dbg_ack SHALL pulse, and the winner's pending flag SHALL clear.
REQ-025 Latency from request pulse (in IDLE) to valid/ack SHALL be 2 cycles; peak throughput is one read per 3 cycles.
REQ-026 regAddr SHALL hold its last value outside READ.
REQ-027 A vga_req that arrives while VGA is in service (READ/DONE) SHALL re-set vga_pend with the new address after DONE.

Reset
REQ-028 While resetn=1, the block SHALL force: state IDLE; pending flags, streak, regAddr, vga_data and dbg_data to 0; vga_valid, dbg_ack and dbg_busy to 0.
REQ-029 Reset mid-transaction SHALL abort the transaction with no valid/ack pulse; requests sampled in the reset cycle SHALL be dropped.

Configuration
REQ-030 With VGA_REG_SCHED_STATS_EN defined, the block SHALL add outputs vga_cnt[15:0] and dbg_cnt[15:0]: saturating counts of DONE cycles per requester, reset to 0.
REQ-031 Without VGA_REG_SCHED_STATS_EN, those ports and counters SHALL NOT exist, and all other behaviour SHALL be identical.

Structure
REQ-032 A shared package vga_ds_pkg SHALL hold the FSM state enum (IDLE/READ/DONE), the grant-owner enum (GNT_VGA/GNT_DBG) and the default width constants.
REQ-033 The arbitration decision (pending flags + streak -> owner) SHALL be one sub-module, vga_sched_arb; the FSM and datapath SHALL remain in vga_reg_sched.

Verification
REQ-034 VGA only: vga_req with vga_addr=3 and register 3=0xDEADBEEF -> regAddr=3 in the READ cycle; vga_valid 2 cycles later with vga_data=0xDEADBEEF; dbg_ack stays 0.
REQ-035 Simultaneous requests: vga_req(addr 1) and dbg_req(addr 2) in the same cycle -> VGA is served first, then debug; dbg_ack 5 cycles after the requests with register-2 data.
REQ-036 Starvation: debug pending while 6 VGA requests are issued back to back -> exactly 4 vga_valid pulses, then dbg_ack, then the remaining VGA fetches.
REQ-037 Overwrite and ignore: vga_req addr 5 then addr 7 before grant -> a single fetch of register 7; a second dbg_req while busy -> no extra dbg_ack, and dbg_data is from the first address.
REQ-038 Reset in READ: resetn=1 during READ -> no valid/ack pulse; all outputs 0 the following cycle; a new request afterwards completes normally.
REQ-039 With VGA_REG_SCHED_STATS_EN: 3 VGA and 2 debug reads -> vga_cnt=3 and dbg_cnt=2; force vga_cnt to 0xFFFF, then one more VGA read -> vga_cnt stays 0xFFFF.
